alu32: RTL and testbench



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_comb.sv | 45 ++++
 rtl/alu32.sv | 39 +++
 tb/tb_alu32.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared width, opcode encodings and constants for the alu32 datapath
package alu_pkg;
    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    localparam logic [ALU_WIDTH-1:0] DIV0_RESULT = '1;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational ALU datapath; divider present only when ALU_DIV_EN is defined
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);
    logic [WIDTH:0] sum;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign carry = sum[WIDTH];

    // opcode decode; every encoding assigns a defined result
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sum[WIDTH-1:0];
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
`ifdef ALU_DIV_EN
            OP_DIV:  result = (b == '0) ? WIDTH'(DIV0_RESULT) : a / b;
`else
            OP_DIV:  result = '0;
`endif
            OP_SHL:  result = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[WIDTH-1:1]};
            OP_ROL:  result = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  result = {a[0], a[WIDTH-1:1]};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XNOR: result = ~(a ^ b);
            OP_GT:   result = {{(WIDTH-1){1'b0}}, a > b};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, a == b};
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/alu32.sv
// alu32: registered 32-bit ALU with async active-high reset (divide enabled by ALU_DIV_EN)
module alu32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opALU,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut
);
    logic [WIDTH-1:0] alu_out_d, alu_out_q;
    logic             carry_d, carry_q;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a      (A),
        .b      (B),
        .op     (opALU),
        .result (alu_out_d),
        .carry  (carry_d)
    );

    // capture result and carry every edge; reset clears them at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            carry_q   <= carry_d;
        end
    end

    assign ALU_Out  = alu_out_q;
    assign CarryOut = carry_q;
endmodule

// File: tb/tb_alu32.sv
// tb_alu32: scoreboard-based self-checking bench for alu32
module tb_alu32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  op = '0;
    logic [31:0] alu_out;
    logic        carry;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [31:0] res;
        logic        c;
        string       name;
    } exp_t;

    exp_t sb[$];

    alu32 dut (
        .clk      (clk),
        .rst      (rst),
        .A        (a),
        .B        (b),
        .opALU    (op),
        .ALU_Out  (alu_out),
        .CarryOut (carry)
    );

    always #5 clk = ~clk;

    function automatic logic carry_of(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[32];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        logic [63:0] p;
        case (o)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  begin p = 64'(x) * 64'(y); return p[31:0]; end
`ifdef ALU_DIV_EN
            4'd3:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
`else
            4'd3:  return 32'd0;
`endif
            4'd4:  return x * 2;
            4'd5:  return x / 2;
            4'd6:  return (x << 1) | (x >> 31);
            4'd7:  return (x >> 1) | (x << 31);
            4'd8:  return x & y;
            4'd9:  return x | y;
            4'd10: return x ^ y;
            4'd11: return ~(x | y);
            4'd12: return ~(x & y);
            4'd13: return ~(x ^ y);
            4'd14: return (x > y) ? 32'd1 : 32'd0;
            default: return (x == y) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o,
                         input logic [31:0] r, input string n);
        @(negedge clk);
        a = x;
        b = y;
        op = o;
        sb.push_back('{r, carry_of(x, y), n});
    endtask

    task automatic collect();
        exp_t e;
        @(posedge clk);
        #1;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: out=%h carry=%b with no expectation queued", alu_out, carry);
        end else begin
            e = sb.pop_front();
            if (alu_out !== e.res || carry !== e.c) begin
                fails++;
                $display("FAIL %s: got out=%h carry=%b, expected out=%h carry=%b",
                         e.name, alu_out, carry, e.res, e.c);
            end
        end
    endtask

    task automatic op_check(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o,
                            input logic [31:0] r, input string n);
        drive(x, y, o, r, n);
        collect();
    endtask

    task automatic check_zero(input string n);
        tests++;
        if (alu_out !== 32'd0 || carry !== 1'b0) begin
            fails++;
            $display("FAIL %s: got out=%h carry=%b, expected out=00000000 carry=0", n, alu_out, carry);
        end
    endtask

    task automatic test_reset();
        #1;
        check_zero("reset_initial");
        @(negedge clk);
        rst = 1'b0;
        op_check(32'd3, 32'd4, 4'd0, 32'd7, "pre_reset_add");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("reset_async");
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        drive(32'd9, 32'd9, 4'd0, 32'd18, "inflight");
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("reset_discard");
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        check_zero("reset_after_release");
    endtask

    task automatic test_add();
        op_check(32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, "add_overflow");
        op_check(32'd3, 32'd4, 4'd0, 32'd7, "add_small");
    endtask

    task automatic test_logic();
        op_check(32'd7, 32'd3, 4'd8,  32'd3, "and");
        op_check(32'd7, 32'd3, 4'd9,  32'd7, "or");
        op_check(32'd7, 32'd3, 4'd10, 32'd4, "xor");
        op_check(32'd7, 32'd3, 4'd11, 32'hFFFF_FFF8, "nor");
        op_check(32'd7, 32'd3, 4'd12, 32'hFFFF_FFFC, "nand");
        op_check(32'd7, 32'd3, 4'd13, 32'hFFFF_FFFB, "xnor");
    endtask

    task automatic test_div();
`ifdef ALU_DIV_EN
        op_check(32'd9, 32'd2, 4'd3, 32'd4, "div");
        op_check(32'd9, 32'd0, 4'd3, 32'hFFFF_FFFF, "div_by_zero");
`else
        op_check(32'd9, 32'd2, 4'd3, 32'd0, "div_disabled");
        op_check(32'd9, 32'd0, 4'd3, 32'd0, "div_disabled_zero");
`endif
    endtask

    task automatic test_shift();
        op_check(32'h8000_0001, 32'd0, 4'd4, 32'h0000_0002, "shl");
        op_check(32'h8000_0001, 32'd0, 4'd5, 32'h4000_0000, "shr");
        op_check(32'h8000_0001, 32'd0, 4'd6, 32'h0000_0003, "rol");
        op_check(32'h8000_0001, 32'd0, 4'd7, 32'hC000_0000, "ror");
    endtask

    task automatic test_compare();
        op_check(32'd5, 32'd5, 4'd15, 32'd1, "eq_equal");
        op_check(32'd5, 32'd5, 4'd14, 32'd0, "gt_equal");
        op_check(32'd6, 32'd5, 4'd14, 32'd1, "gt_greater");
        op_check(32'd5, 32'd5, 4'd1,  32'd0, "sub_equal");
        op_check(32'd2, 32'd5, 4'd1,  32'hFFFF_FFFD, "sub_wrap");
        op_check(32'h0001_0000, 32'h0001_0000, 4'd2, 32'd0, "mul_wrap");
    endtask

    task automatic test_sample_edge();
        op_check(32'd1, 32'd1, 4'd0, 32'd2, "edge_first");
        @(negedge clk);
        a = 32'd100;
        b = 32'd0;
        op = 4'd0;
        sb.push_back('{32'd100, 1'b0, "edge_second"});
        #2;
        tests++;
        if (alu_out !== 32'd2) begin
            fails++;
            $display("FAIL edge_hold: got out=%h, expected out=00000002", alu_out);
        end
        collect();
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        logic [3:0]  o;
        for (int i = 0; i < 16; i++) begin
            x = 32'($urandom_range(0, 9));
            y = 32'($urandom_range(0, 9));
            o = 4'(i);
            drive(x, y, o, model(x, y, o), $sformatf("sweep_op%0d", i));
            collect();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_div();
        test_shift();
        test_compare();
        test_sample_edge();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
